// File: rtl/axis_mii_rx_pkg.sv
// rtl/axis_mii_rx_pkg.sv - shared constants for the MII receive front end
package axis_mii_rx_pkg;

  // CRC-32 (Ethernet FCS) parameters; residue is the raw register value after
  // clocking a good frame's FCS through the non-inverted reflected CRC
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;

  localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0] SFD_NIBBLE      = 4'hD;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_DROP     = 2'd0;
  localparam rx_state_t ST_IDLE     = 2'd1;
  localparam rx_state_t ST_PREAMBLE = 2'd2;
  localparam rx_state_t ST_DATA     = 2'd3;

endpackage

// File: rtl/axis_mii_rx_lfsr.sv
// rtl/axis_mii_rx_lfsr.sv - reversed Galois LFSR advanced by one data word
module axis_mii_rx_lfsr
  import axis_mii_rx_pkg::*;
#(
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = CRC_POLY,
  parameter int                    DATA_WIDTH = 8
) (
  input  logic [LFSR_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  logic [LFSR_WIDTH-1:0] poly_rev;

  // bit-reverse the polynomial so the register shifts toward bit 0 (LSB-first data)
  always_comb begin
    poly_rev = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      poly_rev[i] = LFSR_POLY[LFSR_WIDTH-1-i];
    end
  end

  // fold in data LSB first; feedback is reduced into the register each step
  always_comb begin
    state_out = state_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (state_out[0] ^ data_in[i]) begin
        state_out = (state_out >> 1) ^ poly_rev;
      end else begin
        state_out = state_out >> 1;
      end
    end
  end

endmodule

// File: rtl/axis_mii_rx.sv
// rtl/axis_mii_rx.sv - MII receive front end: preamble strip, FCS check, AXI stream out
module axis_mii_rx
  import axis_mii_rx_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mii_rx_ce,
  input  logic       mii_rx_dv,
  input  logic       mii_rx_er,
  input  logic [3:0] mii_rxd,
  output logic [7:0] axis_data,
  output logic       axis_valid,
  output logic       axis_last,
  output logic       axis_err,
  output logic       frame_ok,
  output logic       fcs_error,
  output logic       align_error,
  output logic       too_short,
  output logic       too_long,
  output logic       rx_error
);

  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME_BYTES);

  rx_state_t   state;
  logic        hi_phase;      // next DATA nibble is the high half of an octet
  logic [3:0]  low_nib;
  logic [7:0]  dl [0:4];      // FCS-strip delay line, dl[0] is oldest
  logic [2:0]  dl_cnt;
  logic [10:0] oct_cnt;
  logic [31:0] crc;
  logic        rx_err_seen;

  logic [7:0]  rx_octet;
  logic [31:0] crc_next;
  logic [10:0] oct_cnt_inc;
  logic        eof_fcs;
  logic        eof_align;
  logic        eof_short;
  logic        eof_bad;

  assign rx_octet    = {mii_rxd, low_nib};
  assign oct_cnt_inc = (oct_cnt == 11'h7FF) ? oct_cnt : oct_cnt + 11'd1;

  assign eof_fcs   = (crc != CRC_RESIDUE);
  assign eof_align = hi_phase;
  assign eof_short = (oct_cnt < MIN_CNT);
  assign eof_bad   = eof_fcs | eof_align | eof_short | rx_err_seen;

  axis_mii_rx_lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (CRC_POLY),
    .DATA_WIDTH (8)
  ) u_crc (
    .state_in  (crc),
    .data_in   (rx_octet),
    .state_out (crc_next)
  );

  // receive FSM, octet assembly, delay line and registered stream/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_DROP;
      hi_phase    <= 1'b0;
      low_nib     <= 4'h0;
      dl_cnt      <= 3'd0;
      oct_cnt     <= 11'd0;
      crc         <= CRC_INIT;
      rx_err_seen <= 1'b0;
      for (int i = 0; i < 5; i++) dl[i] <= 8'h00;
      axis_data   <= 8'h00;
      axis_valid  <= 1'b0;
      axis_last   <= 1'b0;
      axis_err    <= 1'b0;
      frame_ok    <= 1'b0;
      fcs_error   <= 1'b0;
      align_error <= 1'b0;
      too_short   <= 1'b0;
      too_long    <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      axis_valid  <= 1'b0;
      axis_last   <= 1'b0;
      axis_err    <= 1'b0;
      frame_ok    <= 1'b0;
      fcs_error   <= 1'b0;
      align_error <= 1'b0;
      too_short   <= 1'b0;
      too_long    <= 1'b0;
      rx_error    <= 1'b0;
      if (mii_rx_ce) begin
        case (state)
          ST_DROP: begin
            if (!mii_rx_dv) state <= ST_IDLE;
          end
          ST_IDLE: begin
            // first nibble of a burst is itself preamble; an SFD here has no 0x5 before it
            if (mii_rx_dv) begin
              state <= (mii_rxd == PREAMBLE_NIBBLE) ? ST_PREAMBLE : ST_DROP;
            end
          end
          ST_PREAMBLE: begin
            if (!mii_rx_dv) begin
              state <= ST_IDLE;
            end else if (mii_rxd == SFD_NIBBLE) begin
              state       <= ST_DATA;
              hi_phase    <= 1'b0;
              dl_cnt      <= 3'd0;
              oct_cnt     <= 11'd0;
              crc         <= CRC_INIT;
              rx_err_seen <= 1'b0;
            end else if (mii_rxd != PREAMBLE_NIBBLE) begin
              state <= ST_DROP;
            end
          end
          default: begin
            if (!mii_rx_dv) begin
              // end of frame: flush oldest octet as last, remaining four are the FCS
              state       <= ST_IDLE;
              hi_phase    <= 1'b0;
              frame_ok    <= ~eof_bad;
              fcs_error   <= eof_fcs;
              align_error <= eof_align;
              too_short   <= eof_short;
              rx_error    <= rx_err_seen;
              if (dl_cnt == 3'd5) begin
                axis_valid <= 1'b1;
                axis_data  <= dl[0];
                axis_last  <= 1'b1;
                axis_err   <= eof_bad;
              end
            end else begin
              if (mii_rx_er) rx_err_seen <= 1'b1;
              if (!hi_phase) begin
                low_nib  <= mii_rxd;
                hi_phase <= 1'b1;
              end else begin
                hi_phase <= 1'b0;
                crc      <= crc_next;
                oct_cnt  <= oct_cnt_inc;
                if (oct_cnt == MAX_CNT) begin
                  // octet MAX+1 just completed: cut the frame here and ignore the rest
                  state      <= ST_DROP;
                  axis_valid <= 1'b1;
                  axis_data  <= dl[0];
                  axis_last  <= 1'b1;
                  axis_err   <= 1'b1;
                  too_long   <= 1'b1;
                end else if (dl_cnt == 3'd5) begin
                  axis_valid <= 1'b1;
                  axis_data  <= dl[0];
                  for (int i = 0; i < 4; i++) dl[i] <= dl[i+1];
                  dl[4] <= rx_octet;
                end else begin
                  dl[dl_cnt] <= rx_octet;
                  dl_cnt     <= dl_cnt + 3'd1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule
